// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the synchronous FIFO family.
//   fifo_mode_e : read-port mode (registered read or first-word fall-through)
//   cnt_width() : width of an occupancy counter able to hold 0..depth
//   ptr_width() : width of a pointer addressing 0..depth-1 (never below 1)
// -----------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic [0:0] {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Occupancy ranges 0..depth inclusive, hence depth+1 distinct values.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 32'sd1);
   endfunction

   // Pointer ranges 0..depth-1; clamp to one bit so degenerate depths still elaborate.
   function automatic int ptr_width(input int depth);
      return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_wrap_ptr.sv
// -----------------------------------------------------------------------------
// fifo_wrap_ptr
// Circular pointer over 0..DEPTH-1 with an explicit wrap from DEPTH-1 to 0,
// so DEPTH need not be a power of two.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset (pointer -> 0)
//   clr   in  synchronous flush (pointer -> 0), wins over inc
//   inc   in  advance pointer by one entry
//   ptr   out current pointer value
// -----------------------------------------------------------------------------
module fifo_wrap_ptr
   import fifo_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PW    = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);
   localparam logic [PW-1:0] ONE_C  = PW'(1);

   logic [PW-1:0] ptr_r;

   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_wrap_ptr: DEPTH must be at least 2");
   end

   // Pointer register: flush first, then advance with explicit wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (clr) begin
         ptr_r <= '0;
      end else if (inc) begin
         if (ptr_r == LAST_C) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= ptr_r + ONE_C;
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr = ptr_r;

endmodule : fifo_wrap_ptr

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock elastic buffer of DEPTH words of WIDTH bits (any DEPTH >= 2),
// with registered-read or first-word-fall-through read port, programmable
// almost-full / almost-empty thresholds, occupancy count and synchronous flush.
//
// Optional build macro: SYNC_FIFO_ERR_FLAGS_EN
//   When defined, adds sticky overflow/underflow outputs set by a rejected
//   push/pop and cleared by rst_n or clr.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clr          in   synchronous flush, priority over push/pop
//   push         in   write request
//   data_in      in   write data [WIDTH]
//   pop          in   read request
//   data_out     out  read data [WIDTH] (registered)
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  occupancy [cnt_width(DEPTH)]
//   overflow     out  sticky rejected-push flag   (macro only)
//   underflow    out  sticky rejected-pop flag    (macro only)
// -----------------------------------------------------------------------------
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter  int WIDTH    = 64,
   parameter  int DEPTH    = 8,
   parameter  int FWFT     = 0,
   parameter  int AF_LEVEL = DEPTH - 1,
   parameter  int AE_LEVEL = 1,
   localparam int CW       = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   output logic             overflow,
   output logic             underflow,
`endif
   output logic [CW-1:0]    count
);

   localparam int              PW         = ptr_width(DEPTH);
   localparam fifo_mode_e      MODE_C     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
   localparam logic [PW-1:0]   LAST_C     = PW'(DEPTH - 1);
   localparam logic [PW-1:0]   PTR_ONE_C  = PW'(1);
   localparam logic [CW-1:0]   CNT_ONE_C  = CW'(1);
   localparam logic [CW-1:0]   CNT_FULL_C = CW'(DEPTH);
   localparam logic            AF_RST_C   = (AF_LEVEL == 0) ? 1'b1 : 1'b0;

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be at least 2");
   end
   if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_thr
      $error("sync_fifo_param: thresholds must satisfy 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [CW-1:0]    count_r;
   logic             full_r;
   logic             empty_r;
   logic             af_r;
   logic             ae_r;
   logic [WIDTH-1:0] dout_r;

   logic [PW-1:0]    rd_ptr_s;
   logic [PW-1:0]    wr_ptr_s;
   logic [PW-1:0]    rd_nxt_s;
   logic             push_ok_s;
   logic             pop_ok_s;
   logic             wr_en_s;
   logic [CW-1:0]    cnt_nxt_s;
   logic [WIDTH-1:0] dout_nxt_s;

   // Accept decode: a pop frees a slot so push is legal even when full;
   // an empty FIFO never bypasses a same-cycle push to the reader.
   always_comb begin
      pop_ok_s  = pop & ~empty_r;
      push_ok_s = push & (~full_r | pop_ok_s);
      wr_en_s   = push_ok_s & ~clr;
   end

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (pop_ok_s),
      .ptr   (rd_ptr_s)
   );

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (push_ok_s),
      .ptr   (wr_ptr_s)
   );

   // Next occupancy and next read pointer (mirror of the rd pointer instance).
   always_comb begin
      cnt_nxt_s = count_r;
      rd_nxt_s  = rd_ptr_s;
      if (clr) begin
         cnt_nxt_s = '0;
         rd_nxt_s  = '0;
      end else begin
         if (push_ok_s && !pop_ok_s) begin
            cnt_nxt_s = count_r + CNT_ONE_C;
         end else if (pop_ok_s && !push_ok_s) begin
            cnt_nxt_s = count_r - CNT_ONE_C;
         end else begin
            cnt_nxt_s = count_r;
         end
         if (pop_ok_s) begin
            rd_nxt_s = (rd_ptr_s == LAST_C) ? '0 : (rd_ptr_s + PTR_ONE_C);
         end else begin
            rd_nxt_s = rd_ptr_s;
         end
      end
   end

   // Next read-port value. In FWFT mode the head word is pre-computed so the
   // output stays registered; the head slot being written this same edge
   // (push into empty, or push+pop at count 1) must forward data_in.
   always_comb begin
      dout_nxt_s = dout_r;
      case (MODE_C)
         FIFO_FWFT: begin
            if (cnt_nxt_s == '0) begin
               dout_nxt_s = '0;
            end else if (wr_en_s && (wr_ptr_s == rd_nxt_s)) begin
               dout_nxt_s = data_in;
            end else begin
               dout_nxt_s = mem_r[rd_nxt_s];
            end
         end
         FIFO_STD: begin
            if (pop_ok_s && !clr) begin
               dout_nxt_s = mem_r[rd_ptr_s];
            end else begin
               dout_nxt_s = dout_r;
            end
         end
         default: begin
            dout_nxt_s = dout_r;
         end
      endcase
   end

   // Storage array; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_s] <= data_in;
      end
   end

   // Occupancy, status flags and read data. Flags are decoded from the next
   // count so they line up with count in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
         af_r    <= AF_RST_C;
         ae_r    <= 1'b1;
         dout_r  <= '0;
      end else begin
         count_r <= cnt_nxt_s;
         full_r  <= (cnt_nxt_s == CNT_FULL_C);
         empty_r <= (cnt_nxt_s == '0);
         af_r    <= (int'(cnt_nxt_s) >= AF_LEVEL);
         ae_r    <= (int'(cnt_nxt_s) <= AE_LEVEL);
         dout_r  <= dout_nxt_s;
      end
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic ovf_r;
   logic udf_r;

   // Sticky error flags: set by a dropped request, cleared by flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else if (clr) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r | (push & ~push_ok_s);
         udf_r <= udf_r | (pop & ~pop_ok_s);
      end
   end

   assign overflow  = ovf_r;
   assign underflow = udf_r;
`endif

   assign data_out     = dout_r;
   assign full         = full_r;
   assign empty        = empty_r;
   assign almost_full  = af_r;
   assign almost_empty = ae_r;
   assign count        = count_r;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Four FIFO instances share one stimulus bus; each scenario flushes first and
// then checks the instance whose configuration it targets:
//   [0] DEPTH=5 registered read   [1] DEPTH=4 registered read
//   [2] DEPTH=6 registered read   [3] DEPTH=8 FWFT, AF=6, AE=2
// Expected data comes from a scoreboard queue filled when words are pushed.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       push;
   logic       pop;
   logic [7:0] data_in;

   logic [7:0] dout_v [4];
   logic [3:0] full_v;
   logic [3:0] empty_v;
   logic [3:0] af_v;
   logic [3:0] ae_v;
   logic [2:0] cnt_a;
   logic [2:0] cnt_b;
   logic [2:0] cnt_c;
   logic [3:0] cnt_f;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic [3:0] ovf_v;
   logic [3:0] udf_v;
`endif

   int         vectors = 0;
   int         errors  = 0;
   logic [7:0] sb [$];
   logic [7:0] exp_d;

   always #5 clk = ~clk;

   sync_fifo_param #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .data_in(data_in), .pop(pop),
      .data_out(dout_v[0]), .full(full_v[0]), .empty(empty_v[0]),
      .almost_full(af_v[0]), .almost_empty(ae_v[0]),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      .overflow(ovf_v[0]), .underflow(udf_v[0]),
`endif
      .count(cnt_a));

   sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .data_in(data_in), .pop(pop),
      .data_out(dout_v[1]), .full(full_v[1]), .empty(empty_v[1]),
      .almost_full(af_v[1]), .almost_empty(ae_v[1]),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      .overflow(ovf_v[1]), .underflow(udf_v[1]),
`endif
      .count(cnt_b));

   sync_fifo_param #(.WIDTH(8), .DEPTH(6), .FWFT(0)) u_c (
      .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .data_in(data_in), .pop(pop),
      .data_out(dout_v[2]), .full(full_v[2]), .empty(empty_v[2]),
      .almost_full(af_v[2]), .almost_empty(ae_v[2]),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      .overflow(ovf_v[2]), .underflow(udf_v[2]),
`endif
      .count(cnt_c));

   sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_f (
      .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .data_in(data_in), .pop(pop),
      .data_out(dout_v[3]), .full(full_v[3]), .empty(empty_v[3]),
      .almost_full(af_v[3]), .almost_empty(ae_v[3]),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      .overflow(ovf_v[3]), .underflow(udf_v[3]),
`endif
      .count(cnt_f));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests; returns 1 time unit after the rising edge.
   task automatic cyc(input logic p, input logic q, input logic [7:0] d, input logic c);
      push    = p;
      pop     = q;
      data_in = d;
      clr     = c;
      @(posedge clk);
      #1;
      push    = 1'b0;
      pop     = 1'b0;
      clr     = 1'b0;
      data_in = 8'h00;
   endtask

   initial begin
      rst_n   = 1'b0;
      clr     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      data_in = 8'h00;
      #12;
      // ---- reset state ----
      chk("rst_count_a", 64'(cnt_a), 64'(0));
      chk("rst_empty_a", 64'(empty_v[0]), 64'(1));
      chk("rst_full_a",  64'(full_v[0]), 64'(0));
      chk("rst_ae_a",    64'(ae_v[0]), 64'(1));
      chk("rst_af_a",    64'(af_v[0]), 64'(0));
      chk("rst_dout_a",  64'(dout_v[0]), 64'(0));
      chk("rst_dout_f",  64'(dout_v[3]), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // ---- fill and drain, DEPTH=5 ----
      for (int i = 1; i <= 5; i++) begin
         exp_d = 8'(i * 17);
         cyc(1'b1, 1'b0, exp_d, 1'b0);
         sb.push_back(exp_d);
      end
      chk("fill_full_a",  64'(full_v[0]), 64'(1));
      chk("fill_count_a", 64'(cnt_a), 64'(sb.size()));
      chk("fill_af_a",    64'(af_v[0]), 64'(1));
      cyc(1'b1, 1'b0, 8'h66, 1'b0);
      chk("ovf_count_a",  64'(cnt_a), 64'(sb.size()));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("ovf_flag_a",   64'(ovf_v[0]), 64'(1));
`endif
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, 8'h00, 1'b0);
         exp_d = sb.pop_front();
         chk("drain_dout_a", 64'(dout_v[0]), 64'(exp_d));
      end
      chk("drain_empty_a", 64'(empty_v[0]), 64'(1));
      chk("drain_count_a", 64'(cnt_a), 64'(0));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("hold_dout_a",   64'(dout_v[0]), 64'(exp_d));

      // ---- push+pop while full, DEPTH=4 ----
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      sb.delete();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("clr_ovf_a", 64'(ovf_v[0]), 64'(0));
`endif
      for (int i = 0; i < 4; i++) begin
         exp_d = 8'(8'hA0 + 8'(i * 16));
         cyc(1'b1, 1'b0, exp_d, 1'b0);
         sb.push_back(exp_d);
      end
      chk("full_b", 64'(full_v[1]), 64'(1));
      cyc(1'b1, 1'b1, 8'hE0, 1'b0);
      exp_d = sb.pop_front();
      sb.push_back(8'hE0);
      chk("pp_dout_b",  64'(dout_v[1]), 64'(exp_d));
      chk("pp_count_b", 64'(cnt_b), 64'(sb.size()));
      chk("pp_full_b",  64'(full_v[1]), 64'(1));
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 8'h00, 1'b0);
         exp_d = sb.pop_front();
         chk("pp_drain_b", 64'(dout_v[1]), 64'(exp_d));
      end
      chk("pp_empty_b", 64'(empty_v[1]), 64'(1));

      // ---- pointer wrap, DEPTH=6, steady count 3 ----
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      sb.delete();
      for (int i = 1; i <= 3; i++) begin
         cyc(1'b1, 1'b0, 8'(i), 1'b0);
         sb.push_back(8'(i));
      end
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b1, 8'(8'h10 + 8'(i)), 1'b0);
         sb.push_back(8'(8'h10 + 8'(i)));
         exp_d = sb.pop_front();
         chk("wrap_dout_c",  64'(dout_v[2]), 64'(exp_d));
         chk("wrap_count_c", 64'(cnt_c), 64'(sb.size()));
      end

      // ---- FWFT, DEPTH=8 ----
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      sb.delete();
      chk("fwft_empty0", 64'(empty_v[3]), 64'(1));
      cyc(1'b1, 1'b0, 8'hAB, 1'b0);
      sb.push_back(8'hAB);
      chk("fwft_empty1", 64'(empty_v[3]), 64'(0));
      chk("fwft_show",   64'(dout_v[3]), 64'(sb[0]));
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("fwft_hold",   64'(dout_v[3]), 64'(sb[0]));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      void'(sb.pop_front());
      chk("fwft_empty2", 64'(empty_v[3]), 64'(1));
      chk("fwft_zero",   64'(dout_v[3]), 64'(0));
      cyc(1'b1, 1'b0, 8'hC1, 1'b0);
      sb.push_back(8'hC1);
      cyc(1'b1, 1'b0, 8'hC2, 1'b0);
      sb.push_back(8'hC2);
      chk("fwft_head1", 64'(dout_v[3]), 64'(sb[0]));
      cyc(1'b1, 1'b1, 8'hC3, 1'b0);
      void'(sb.pop_front());
      sb.push_back(8'hC3);
      chk("fwft_head2", 64'(dout_v[3]), 64'(sb[0]));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      void'(sb.pop_front());
      chk("fwft_head3", 64'(dout_v[3]), 64'(sb[0]));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      void'(sb.pop_front());
      chk("fwft_head4", 64'(dout_v[3]), 64'(sb[0]));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      void'(sb.pop_front());
      chk("fwft_drained", 64'(dout_v[3]), 64'(0));
      chk("fwft_empty3",  64'(empty_v[3]), 64'(1));

      // ---- thresholds AF=6, AE=2 ----
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         cyc(1'b1, 1'b0, 8'(k), 1'b0);
         chk("thr_count_f", 64'(cnt_f), 64'(k));
         chk("thr_af_f",    64'(af_v[3]), 64'(k >= 6));
         chk("thr_ae_f",    64'(ae_v[3]), 64'(k <= 2));
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("thr_clr_count", 64'(cnt_f), 64'(0));
      chk("thr_clr_empty", 64'(empty_v[3]), 64'(1));
      chk("thr_clr_ae",    64'(ae_v[3]), 64'(1));
      chk("thr_clr_af",    64'(af_v[3]), 64'(0));

      // ---- underflow and asynchronous reset mid-stream ----
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("udf_clear_a", 64'(udf_v[0]), 64'(0));
`endif
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("udf_set_a", 64'(udf_v[0]), 64'(1));
`endif
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("udf_held_a", 64'(udf_v[0]), 64'(1));
`endif
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 8'(8'h70 + 8'(i)), 1'b0);
      end
      chk("mid_count_a", 64'(cnt_a), 64'(3));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count_a", 64'(cnt_a), 64'(0));
      chk("arst_count_b", 64'(cnt_b), 64'(0));
      chk("arst_count_c", 64'(cnt_c), 64'(0));
      chk("arst_count_f", 64'(cnt_f), 64'(0));
      for (int i = 0; i < 4; i++) begin
         chk("arst_dout", 64'(dout_v[i]), 64'(0));
      end
      chk("arst_full",  64'(full_v), 64'(4'b0000));
      chk("arst_empty", 64'(empty_v), 64'(4'b1111));
      chk("arst_ae",    64'(ae_v), 64'(4'b1111));
      chk("arst_af",    64'(af_v), 64'(4'b0000));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("arst_udf",   64'(udf_v), 64'(4'b0000));
      chk("arst_ovf",   64'(ovf_v), 64'(4'b0000));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_sync_fifo_param

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Second-generation single-clock FIFO for the data-transfer protocol blocks. Generalised in width and depth; depth need not be a power of two.
- Adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count and a synchronous flush.
- Sits between protocol front-ends (UART/SPI/I2C framers) and their consumers as the standard elastic buffer.

Parameters:
- WIDTH, 64, data word width in bits (>=1)
- DEPTH, 8, number of entries (>=2, any integer; elaboration error if <2)
- FWFT, 0, 0 = registered read (data valid cycle after pop); 1 = first-word fall-through
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush; empties FIFO, priority over push/pop
- push  in  1  write request
- data_in  in  WIDTH  write data
- pop  in  1  read request
- data_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: rd_ptr, wr_ptr and count are 0; data_out is 0; empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0). Memory contents are not reset.
- Accept rules: push_ok = push && (!full || pop_ok). pop_ok = pop && !empty.
  - Push and pop together while full: both accepted, count unchanged.
  - Push and pop together while empty: only the push is accepted. The pop is dropped (underflow) and there is no bypass.
- Pointers range 0..DEPTH-1 with explicit wrap: ptr == DEPTH-1 -> 0. No power-of-two masking.
- Count:
  - count += push_ok - pop_ok.
  - Status flags are combinational decodes of count and are registered-consistent, i.e. valid the cycle after the edge that changed count.
- FWFT=0:
  - On pop_ok, data_out <= mem[rd_ptr] at that edge.
  - data_out holds its value otherwise, including while empty.
  - Read latency is 1 cycle after pop.
- FWFT=1:
  - data_out = mem[rd_ptr] whenever !empty, and forced to 0 when empty.
  - A word pushed into an empty FIFO is visible with empty=0 the cycle after the push edge.
  - pop acknowledges the currently shown word; the next word appears the cycle after.
- clr: at the edge, pointers and count go to 0. Concurrent push/pop are ignored. In FWFT=0, data_out is unchanged.
- Rejected operations (push while full without pop, pop while empty) change no state.
- Asynchronous reset mid-operation: all state returns to reset values immediately; in-flight data is lost.
- Threshold legality (elaboration error otherwise): 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.

Optional Feature:
- Macro SYNC_FIFO_ERR_FLAGS_EN.
- When defined: adds outputs overflow (1) and underflow (1).
  - These are sticky flags set by a rejected push or a rejected pop respectively.
  - Cleared by rst_n or clr; reset value 0.
- When undefined: these ports and their logic are absent; rejected operations are silently dropped.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e enum: FIFO_STD, FIFO_FWFT.
  - Function cnt_width(depth) returning $clog2(depth+1).
- Sub-module fifo_wrap_ptr (param DEPTH):
  - Inputs: clk, rst_n, clr, inc.
  - Output: ptr [$clog2(DEPTH)-1:0] with non-power-of-two wrap.
  - Instantiated twice, for rd and wr.

Test Plan:
- Fill and drain, DEPTH=5, WIDTH=8, FWFT=0:
  - Push 0x11..0x55 -> full=1 and count=5 after the 5th edge.
  - Push 0x66 rejected -> count stays 5.
  - Pop 5 times -> data_out sequence 0x11..0x55 at one cycle of latency each; then empty=1.
- Simultaneous push/pop while full, DEPTH=4 holding A,B,C,D:
  - push E + pop -> data_out=A, count=4.
  - Then drain -> B,C,D,E.
- Pointer wrap, DEPTH=6:
  - 20 push/pop pairs interleaved at count 3 -> output order equals input order; count never leaves 3.
- FWFT=1:
  - Push 0xAB into empty -> next cycle empty=0, data_out=0xAB with no pop.
  - Pop -> empty=1 and data_out=0 the following cycle.
- Thresholds, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2:
  - Push 6 words -> almost_full rises on the 6th, almost_empty falls on the 3rd.
  - clr -> count=0, empty=1, almost_empty=1.
- Reset mid-stream, with SYNC_FIFO_ERR_FLAGS_EN defined:
  - Pop while empty -> underflow=1 and held.
  - Push 3 words, then assert rst_n=0 asynchronously -> count=0, data_out=0, underflow=0 immediately.
